// File: rtl/tamagotchi_pkg.sv
// Definitions shared by the tamagotchi blocks.
//   - estado codes produced by the state FSM (3-bit).
//   - Bounds and width of the need levels (hambre / diversion).
//   - Saturating step helpers for those levels.
package tamagotchi_pkg;

    localparam logic [2:0] NEUTRO     = 3'd0;
    localparam logic [2:0] FELIZ      = 3'd1;
    localparam logic [2:0] TRISTE     = 3'd2;
    localparam logic [2:0] CANSADO    = 3'd3;
    localparam logic [2:0] HAMBRIENTO = 3'd4;
    localparam logic [2:0] MUERTO     = 3'd5;

    localparam int NIVEL_W = 3;
    localparam logic [NIVEL_W-1:0] NIVEL_MIN = NIVEL_W'(1);
    localparam logic [NIVEL_W-1:0] NIVEL_MAX = NIVEL_W'(5);

    // +1, clamped to NIVEL_MAX.
    function automatic logic [NIVEL_W-1:0] nivel_inc(input logic [NIVEL_W-1:0] n);
        return (n >= NIVEL_MAX) ? NIVEL_MAX : n + NIVEL_W'(1);
    endfunction

    // -1, clamped to NIVEL_MIN.
    function automatic logic [NIVEL_W-1:0] nivel_dec(input logic [NIVEL_W-1:0] n);
        return (n <= NIVEL_MIN) ? NIVEL_MIN : n - NIVEL_W'(1);
    endfunction

endpackage

// File: rtl/gestor_niveles_if.sv
// Signal bundle between gestor_niveles and its environment (FSM + buttons).
//   btn_comer_n, btn_jugar_n : active-low raw buttons, asynchronous to clk
//   acelerar                 : time acceleration level, synchronous
//   estado                   : FSM state code
//   hambre, diversion        : need levels, always within 1..5
//   comer_ok, jugar_ok       : one-cycle pulses, press accepted
// There is no valid/ready handshake here: levels are continuously valid
// and the ok signals are single-cycle strobes that need no acknowledge.
// master = the side that drives buttons/estado; slave = gestor_niveles.
interface gestor_niveles_if;
    import tamagotchi_pkg::*;

    logic               btn_comer_n;
    logic               btn_jugar_n;
    logic               acelerar;
    logic [2:0]         estado;
    logic [NIVEL_W-1:0] hambre;
    logic [NIVEL_W-1:0] diversion;
    logic               comer_ok;
    logic               jugar_ok;

    modport master (
        output btn_comer_n, btn_jugar_n, acelerar, estado,
        input  hambre, diversion, comer_ok, jugar_ok
    );

    modport slave (
        input  btn_comer_n, btn_jugar_n, acelerar, estado,
        output hambre, diversion, comer_ok, jugar_ok
    );

endinterface

// File: rtl/debounce_pulso.sv
// Button conditioner: 2-FF synchronizer, debouncer and press-edge pulse.
//   clk, reset_n : clock, asynchronous active-low reset
//   btn_n        : raw active-low button
//   pulso        : one-cycle pulse when the debounced state goes
//                  released -> pressed; nothing on release
// The stable state only changes after the synchronized level has differed
// from it for DEBOUNCE_CYC consecutive cycles.
module debounce_pulso #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic pulso
);

    localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;    // reset to "released" (high)
    logic             pulsado;   // synchronized level, 1 = pressed
    logic             estable;   // debounced state, 1 = pressed
    logic [CNT_W-1:0] cnt;

    assign pulsado = ~sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estable <= 1'b0;
            cnt     <= '0;
            pulso   <= 1'b0;
        end else begin
            pulso <= 1'b0;
            if (pulsado != estable) begin
                if (cnt == CNT_LAST) begin
                    estable <= pulsado;
                    cnt     <= '0;
                    // Only the transition into "pressed" is an event.
                    pulso   <= pulsado;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                // Any bounce back to the stable level restarts the count.
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gestor_niveles.sv
// Need-level manager for the tamagotchi.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : buttons, acelerar and estado in; hambre, diversion,
//                  comer_ok and jugar_ok out (see gestor_niveles_if)
// A prescaler produces a one-second tick. Hunger rises every T_HAMBRE_S
// ticks, fun decays every T_DIVERSION_S ticks (halved while CANSADO).
// Feed/play presses move the levels back and restart the matching timer.
// While MUERTO everything is frozen and presses are discarded.
module gestor_niveles
    import tamagotchi_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int T_HAMBRE_S    = 10,
    parameter int T_DIVERSION_S = 15,
    parameter int DEBOUNCE_CYC  = 1_000_000,
    parameter int TEST_DIV      = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    gestor_niveles_if.slave   bus
);

    localparam int SEC_NORMAL    = CLK_HZ;
    localparam int SEC_RAPIDO    = (CLK_HZ / TEST_DIV < 1) ? 1 : CLK_HZ / TEST_DIV;
    localparam int T_DIV_CANSADO = (T_DIVERSION_S / 2 < 1) ? 1 : T_DIVERSION_S / 2;

    localparam int PRE_W = $clog2(CLK_HZ + 1);
    localparam int TH_W  = $clog2(T_HAMBRE_S + 1);
    localparam int TD_W  = $clog2(T_DIVERSION_S + 1);

    logic [PRE_W-1:0]   pre_cnt;
    logic [PRE_W-1:0]   pre_last;
    logic               acelerar_q;
    logic               cambio_vel;
    logic               seg_tick;
    logic               muerto;
    logic               cansado;

    logic [TH_W-1:0]    t_hambre;
    logic [TD_W-1:0]    t_div;
    logic [TD_W-1:0]    t_div_lim;
    logic               exp_hambre;
    logic               exp_div;

    logic               ev_comer;
    logic               ev_jugar;
    logic               comer;
    logic               jugar;

    logic [NIVEL_W-1:0] hambre_q;
    logic [NIVEL_W-1:0] diversion_q;
    logic               comer_ok_q;
    logic               jugar_ok_q;

    // Codes 6 and 7 match neither compare, so they behave as NEUTRO.
    assign muerto  = (bus.estado == MUERTO);
    assign cansado = (bus.estado == CANSADO);

    // ---------------- button conditioning ----------------
    debounce_pulso #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_comer (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (bus.btn_comer_n),
        .pulso   (ev_comer)
    );

    debounce_pulso #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_jugar (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (bus.btn_jugar_n),
        .pulso   (ev_jugar)
    );

    // Debouncers keep running while dead; only their events are dropped.
    assign comer = ev_comer && !muerto;
    assign jugar = ev_jugar && !muerto;

    // ---------------- prescaler ----------------
    // acelerar_q only remembers the previous acelerar level to detect a
    // change; it holds no count, so it tracks the input even during reset.
    always_ff @(posedge clk) begin
        acelerar_q <= bus.acelerar;
    end

    assign cambio_vel = (bus.acelerar != acelerar_q);
    assign pre_last   = bus.acelerar ? PRE_W'(SEC_RAPIDO - 1) : PRE_W'(SEC_NORMAL - 1);
    assign seg_tick   = !muerto && !cambio_vel && (pre_cnt == pre_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (cambio_vel) begin
            // Cleared even while dead so the count never sits above a
            // freshly shortened period.
            pre_cnt <= '0;
        end else if (!muerto) begin
            pre_cnt <= seg_tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // ---------------- timer thresholds ----------------
    // ">=" rather than "==" lets the fun timer fire on the next tick when
    // entering CANSADO leaves it already past the shorter threshold.
    assign t_div_lim  = cansado ? TD_W'(T_DIV_CANSADO - 1) : TD_W'(T_DIVERSION_S - 1);
    assign exp_hambre = seg_tick && (t_hambre >= TH_W'(T_HAMBRE_S - 1));
    assign exp_div    = seg_tick && (t_div >= t_div_lim);

    // ---------------- hunger ----------------
    // A feed event takes priority over a same-cycle timer expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hambre_q   <= NIVEL_W'(2);
            t_hambre   <= '0;
            comer_ok_q <= 1'b0;
        end else begin
            comer_ok_q <= comer;
            if (comer) begin
                hambre_q <= nivel_dec(hambre_q);
                t_hambre <= '0;
            end else if (exp_hambre) begin
                hambre_q <= nivel_inc(hambre_q);
                t_hambre <= '0;
            end else if (seg_tick) begin
                t_hambre <= t_hambre + TH_W'(1);
            end
        end
    end

    // ---------------- fun ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            diversion_q <= NIVEL_W'(3);
            t_div       <= '0;
            jugar_ok_q  <= 1'b0;
        end else begin
            jugar_ok_q <= jugar;
            if (jugar) begin
                diversion_q <= nivel_inc(diversion_q);
                t_div       <= '0;
            end else if (exp_div) begin
                diversion_q <= nivel_dec(diversion_q);
                t_div       <= '0;
            end else if (seg_tick) begin
                t_div <= t_div + TD_W'(1);
            end
        end
    end

    assign bus.hambre    = hambre_q;
    assign bus.diversion = diversion_q;
    assign bus.comer_ok  = comer_ok_q;
    assign bus.jugar_ok  = jugar_ok_q;

endmodule
